// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: select codes, funct values,
// aluOp meanings, FSM states and the combinational op decoder.
package alu_ctrl_pkg;

    localparam logic [3:0] SEL_ADD   = 4'd0;
    localparam logic [3:0] SEL_SUB   = 4'd1;
    localparam logic [3:0] SEL_AND   = 4'd2;
    localparam logic [3:0] SEL_OR    = 4'd3;
    localparam logic [3:0] SEL_SLL   = 4'd4;
    localparam logic [3:0] SEL_SRL   = 4'd5;
    localparam logic [3:0] SEL_SLT   = 4'd6;
    localparam logic [3:0] SEL_NOR   = 4'd7;
    localparam logic [3:0] SEL_XOR   = 4'd8;
    localparam logic [3:0] SEL_SLTU  = 4'd9;
    localparam logic [3:0] SEL_MULT  = 4'd10;
    localparam logic [3:0] SEL_MULTU = 4'd11;
    localparam logic [3:0] SEL_DIV   = 4'd12;
    localparam logic [3:0] SEL_DIVU  = 4'd13;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ALUOP_ADD = 2'd0;
    localparam logic [1:0] ALUOP_SUB = 2'd1;
    localparam logic [1:0] ALUOP_R   = 2'd2;
    localparam logic [1:0] ALUOP_OR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       illegal;
        logic       is_mdu;
        logic       is_div;
    } dec_t;

    function automatic dec_t decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
        dec_t d;
        d = '{code: SEL_ADD, illegal: 1'b0, is_mdu: 1'b0, is_div: 1'b0};
        case (alu_op)
            ALUOP_ADD: d.code = SEL_ADD;
            ALUOP_SUB: d.code = SEL_SUB;
            ALUOP_OR:  d.code = SEL_OR;
            ALUOP_R: begin
                case (funct)
                    FN_ADD:   d.code = SEL_ADD;
                    FN_SUB:   d.code = SEL_SUB;
                    FN_AND:   d.code = SEL_AND;
                    FN_OR:    d.code = SEL_OR;
                    FN_SLL:   d.code = SEL_SLL;
                    FN_SRL:   d.code = SEL_SRL;
                    FN_SLT:   d.code = SEL_SLT;
                    FN_NOR:   d.code = SEL_NOR;
                    FN_XOR:   d.code = SEL_XOR;
                    FN_SLTU:  d.code = SEL_SLTU;
                    FN_MULT:  begin d.code = SEL_MULT;  d.is_mdu = 1'b1; end
                    FN_MULTU: begin d.code = SEL_MULTU; d.is_mdu = 1'b1; end
                    FN_DIV:   begin d.code = SEL_DIV;   d.is_mdu = 1'b1; d.is_div = 1'b1; end
                    FN_DIVU:  begin d.code = SEL_DIVU;  d.is_mdu = 1'b1; d.is_div = 1'b1; end
                    default:  begin d.code = SEL_ADD;   d.illegal = 1'b1; end
                endcase
            end
            default: begin d.code = SEL_ADD; d.illegal = 1'b1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mdu_cycle_counter.sv
// Down-counter timing an MDU op: loads on accept, decrements while busy,
// saturates at zero and flags it.
module mdu_cycle_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load has priority; decrement never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/alu_control_seq.sv
// ALU control decoder with registered select and a sequencer for the
// multi-cycle multiply/divide unit (valid/ready handshake toward the issuer).
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int SEL_W      = 4,
    parameter int FUNCT_W    = 6,
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluOp,
    input  logic [FUNCT_W-1:0] funct,
    output logic [SEL_W-1:0]   alu_sel,
    output logic               out_valid,
    output logic               illegal,
    output logic               mdu_active,
    output logic               mdu_div,
    output logic               hilo_we
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic             mdu_active_q, mdu_active_d;
    logic             mdu_div_q, mdu_div_d;
    logic             hilo_we_q, hilo_we_d;

    logic             accept_s;
    logic             funct_hi_zero_s;
    logic             cnt_zero_s;
    dec_t             dec_raw_s;
    dec_t             dec_s;

    // A funct wider than 6 bits only decodes when its extra bits are zero.
    generate
        if (FUNCT_W > 6) begin : g_funct_hi
            assign funct_hi_zero_s = (funct[FUNCT_W-1:6] == {(FUNCT_W-6){1'b0}});
        end else begin : g_funct_exact
            assign funct_hi_zero_s = 1'b1;
        end
    endgenerate

    assign dec_raw_s = decode_op(aluOp, funct[5:0]);

    // Fold oversize-funct rejection into the decoded record.
    always_comb begin
        dec_s = dec_raw_s;
        if ((aluOp == ALUOP_R) && !funct_hi_zero_s) begin
            dec_s = '{code: SEL_ADD, illegal: 1'b1, is_mdu: 1'b0, is_div: 1'b0};
        end else begin
            dec_s = dec_raw_s;
        end
    end

    assign in_ready = (state_q != ST_BUSY);
    assign accept_s = in_valid & in_ready;

    mdu_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .load_i     (accept_s & dec_s.is_mdu),
        .load_val_i (dec_s.is_div ? DIV_LOAD : MUL_LOAD),
        .dec_i      (state_q == ST_BUSY),
        .zero_o     (cnt_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s && dec_s.is_mdu) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_zero_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        alu_sel_d    = alu_sel_q;
        illegal_d    = illegal_q;
        mdu_div_d    = mdu_div_q;
        mdu_active_d = mdu_active_q;
        out_valid_d  = 1'b0;
        hilo_we_d    = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (cnt_zero_s) begin
                    out_valid_d  = 1'b1;
                    hilo_we_d    = 1'b1;
                    mdu_active_d = 1'b0;
                end else begin
                    mdu_active_d = 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    alu_sel_d = SEL_W'(dec_s.code);
                    illegal_d = dec_s.illegal;
                    if (dec_s.is_mdu) begin
                        mdu_active_d = 1'b1;
                        mdu_div_d    = dec_s.is_div;
                        out_valid_d  = 1'b0;
                    end else begin
                        mdu_active_d = 1'b0;
                        out_valid_d  = 1'b1;
                    end
                end else begin
                    mdu_active_d = 1'b0;
                end
            end
            default: begin
                alu_sel_d    = {SEL_W{1'b0}};
                illegal_d    = 1'b0;
                mdu_div_d    = 1'b0;
                mdu_active_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_sel_q    <= {SEL_W{1'b0}};
            out_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            mdu_active_q <= 1'b0;
            mdu_div_q    <= 1'b0;
            hilo_we_q    <= 1'b0;
        end else begin
            alu_sel_q    <= alu_sel_d;
            out_valid_q  <= out_valid_d;
            illegal_q    <= illegal_d;
            mdu_active_q <= mdu_active_d;
            mdu_div_q    <= mdu_div_d;
            hilo_we_q    <= hilo_we_d;
        end
    end

    assign alu_sel    = alu_sel_q;
    assign out_valid  = out_valid_q;
    assign illegal    = illegal_q;
    assign mdu_active = mdu_active_q;
    assign mdu_div    = mdu_div_q;
    assign hilo_we    = hilo_we_q;

endmodule
